// File: rtl/uart_rx_deser.sv
// uart_rx_deser: 8N1 UART receiver / deserializer, LSB first, idle-high line.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   rx          : raw serial line, two-flop synchronized before use
//   clear       : consumer acknowledge, drops byte_ready
//   rx_byte     : last accepted data byte (named rx_byte because 'byte' is a
//                 reserved word), stable while byte_ready is high
//   byte_ready  : sticky "byte available" flag
//   frame_err   : one-cycle pulse on a bad stop bit
//   overrun     : one-cycle pulse when a byte is accepted over an unread one
// Optional build macro UART_RX_FRAME_ERR_EN: a stop bit sampled low rejects the
// frame, pulses frame_err and parks in BREAK until the line returns high.
// Without it the stop sample is ignored and frame_err is constant 0.
module uart_rx_deser #(
  parameter int unsigned clock_frequency = 12000000,
  parameter int unsigned uart_baud_rate  = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       clear,
  output logic [7:0] rx_byte,
  output logic       byte_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned DIV  = clock_frequency / uart_baud_rate;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = $clog2(DIV + 1);

`ifdef UART_RX_FRAME_ERR_EN
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitn_q, bitn_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    byte_q, byte_d;
  logic          br_q, br_d;
  logic          fe_q, fe_d;
  logic          ov_q, ov_d;
  logic          rx_meta_q, rx_s_q, rx_prev_q;
  logic          accept;

  // Next-state and datapath logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bitn_d  = bitn_q;
    shreg_d = shreg_q;
    byte_d  = byte_q;
    br_d    = br_q;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
    accept  = 1'b0;

    if (clear) br_d = 1'b0;

    // cnt holds cycles elapsed since the last reference point (T0 or the
    // previous sample), so a sample fires when it reaches HALF or DIV.
    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          state_d = START;
          cnt_d   = CW'(1);
        end
      end
      START: begin
        if (cnt_q == CW'(HALF)) begin
          cnt_d  = CW'(1);
          bitn_d = 3'd0;
          if (!rx_s_q) state_d = DATA;
          else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CW'(DIV)) begin
          cnt_d   = CW'(1);
          shreg_d = {rx_s_q, shreg_q[7:1]};
          bitn_d  = bitn_q + 3'd1;
          if (bitn_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CW'(DIV)) begin
          cnt_d   = '0;
          state_d = IDLE;
`ifdef UART_RX_FRAME_ERR_EN
          if (rx_s_q) accept = 1'b1;
          else begin
            fe_d    = 1'b1;
            state_d = BREAK;
          end
`else
          accept = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef UART_RX_FRAME_ERR_EN
      // Wait for the line to return high so a held-low line is not re-framed
      BREAK: begin
        if (rx_s_q) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    // Acceptance overrides a same-cycle clear
    if (accept) begin
      byte_d = shreg_q;
      br_d   = 1'b1;
      ov_d   = br_q && !clear;
    end
  end

  // State registers and line synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bitn_q    <= 3'd0;
      shreg_q   <= 8'd0;
      byte_q    <= 8'd0;
      br_q      <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitn_q    <= bitn_d;
      shreg_q   <= shreg_d;
      byte_q    <= byte_d;
      br_q      <= br_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end

  assign rx_byte    = byte_q;
  assign byte_ready = br_q;
  assign frame_err  = fe_q;
  assign overrun    = ov_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Self-checking bench for uart_rx_deser at DIV = 1600/100 = 16.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// A frame driven starting at falling edge N0 gives T0 = cycle holding N2, so
// cycle T0+n holds N(n+2): acceptance cycle k9 = N154, result visible at N155.
module tb_uart_rx_deser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       clear;
  logic [7:0] rx_byte;
  logic       byte_ready;
  logic       frame_err;
  logic       overrun;

  int n_pass  = 0;
  int n_total = 0;
  int ov_cnt  = 0;
  int fe_cnt  = 0;

  uart_rx_deser #(.clock_frequency(1600), .uart_baud_rate(100)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .clear      (clear),
    .rx_byte    (rx_byte),
    .byte_ready (byte_ready),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Pulse counters for the one-cycle outputs
  always @(negedge clk) begin
    if (overrun)   ov_cnt++;
    if (frame_err) fe_cnt++;
  end

  typedef struct {
    logic       pre_clr;
    logic [7:0] d;
    logic       stop;
    logic       clr_acc;
    logic       exp_br154;
    logic       exp_br;
    logic [7:0] exp_byte;
    logic       exp_ov;
    logic       exp_fe;
    int         idle_after;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic bitval(input logic [7:0] d, input logic stop, input int i);
    int k;
    k = i / 16;
    if (k == 0) return 1'b0;
    if (k <= 8) return d[3'(k - 1)];
    return stop;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic clr_acc,
                            output logic br154, output logic br155, output logic ov155,
                            output logic fe155, output logic [7:0] by155);
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      if (i == 154) br154 = byte_ready;
      if (i == 155) begin
        br155 = byte_ready;
        ov155 = overrun;
        fe155 = frame_err;
        by155 = rx_byte;
      end
      rx    = bitval(d, stop, i);
      clear = clr_acc && (i == 154);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  logic       br154, br155, ov155, fe155;
  logic [7:0] by155;

  initial begin
    //             pre  data   stop clr  br154 br     byte   ov    fe    idle
    vecs[0] = '{1'b0, 8'h32, 1'b1, 1'b0, 1'b0, 1'b1, 8'h32, 1'b0, 1'b0, 100};
    vecs[1] = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 0};
    vecs[2] = '{1'b0, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 20};
    vecs[3] = '{1'b0, 8'h64, 1'b1, 1'b1, 1'b1, 1'b1, 8'h64, 1'b0, 1'b0, 20};
`ifdef UART_RX_FRAME_ERR_EN
    vecs[4] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h64, 1'b0, 1'b1, 40};
`else
    vecs[4] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 40};
`endif

    rst_n = 1'b0;
    rx    = 1'b1;
    clear = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_byte", 32'(rx_byte), 32'h0);
    check("reset_byte_ready", 32'(byte_ready), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    idle(5);

    // Short low glitch: START must abort without touching outputs
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(200);
    check("glitch_byte_ready", 32'(byte_ready), 32'h0);
    check("glitch_byte", 32'(rx_byte), 32'h0);

    foreach (vecs[n]) begin
      if (vecs[n].pre_clr) begin
        pulse_clear();
        check($sformatf("v%0d_preclear_byte_ready", n), 32'(byte_ready), 32'h0);
      end
      send_frame(vecs[n].d, vecs[n].stop, vecs[n].clr_acc, br154, br155, ov155, fe155, by155);
      check($sformatf("v%0d_byte_ready_before", n), 32'(br154), 32'(vecs[n].exp_br154));
      check($sformatf("v%0d_byte_ready", n), 32'(br155), 32'(vecs[n].exp_br));
      check($sformatf("v%0d_byte", n), 32'(by155), 32'(vecs[n].exp_byte));
      check($sformatf("v%0d_overrun", n), 32'(ov155), 32'(vecs[n].exp_ov));
      check($sformatf("v%0d_frame_err", n), 32'(fe155), 32'(vecs[n].exp_fe));
      if (vecs[n].idle_after > 0) begin
        idle(vecs[n].idle_after);
        check($sformatf("v%0d_hold_byte_ready", n), 32'(byte_ready), 32'(vecs[n].exp_br));
        check($sformatf("v%0d_hold_byte", n), 32'(rx_byte), 32'(vecs[n].exp_byte));
      end
    end

    check("overrun_pulse_count", 32'(ov_cnt), 32'd1);
`ifdef UART_RX_FRAME_ERR_EN
    check("frame_err_pulse_count", 32'(fe_cnt), 32'd1);
`else
    check("frame_err_pulse_count", 32'(fe_cnt), 32'd0);
`endif

    // Reset asserted at the k=4 sample of frame 0x66
    for (int i = 0; i < 74; i++) begin
      @(negedge clk);
      rx = bitval(8'h66, 1'b1, i);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_byte", 32'(rx_byte), 32'h0);
    check("midreset_byte_ready", 32'(byte_ready), 32'h0);
    check("midreset_frame_err", 32'(frame_err), 32'h0);
    check("midreset_overrun", 32'(overrun), 32'h0);
    rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    idle(40);
    check("postreset_no_frame", 32'(byte_ready), 32'h0);

    send_frame(8'h0F, 1'b1, 1'b0, br154, br155, ov155, fe155, by155);
    check("f0f_byte_ready_before", 32'(br154), 32'h0);
    check("f0f_byte_ready", 32'(br155), 32'h1);
    check("f0f_byte", 32'(by155), 32'h0F);
    check("f0f_overrun", 32'(ov155), 32'h0);
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
